// File: rtl/mem_access_unit.sv
// Load/store front end for the word-only data port of dpram.
// Byte and halfword loads are pulled out of the addressed word and then
// zero- or sign-extended. Byte and halfword stores are done as a
// read-modify-write sequence. Memory is big-endian: byte offset 0 of a
// word is bits [31:24].
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  output logic                  resp_err_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_RMW_RD = 3'd2;
  localparam logic [2:0] S_STORE  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [2:0]            state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] merge_q, merge_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  // Half must sit on an even byte, a word on a multiple of four bytes;
  // size 11 is never legal.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      SZ_BYTE: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Pick out the addressed lane and extend it to a full word.
  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (size)
      SZ_BYTE: r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Overwrite the addressed lane of the old word with right-aligned store data.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] size, input logic [1:0] off);
    logic [31:0] r;
    r = old;
    if (size == SZ_BYTE) begin
      case (off)
        2'd0:    r[31:24] = wd[7:0];
        2'd1:    r[23:16] = wd[7:0];
        2'd2:    r[15:8]  = wd[7:0];
        default: r[7:0]   = wd[7:0];
      endcase
    end else if (off[1]) begin
      r[15:0] = wd[15:0];
    end else begin
      r[31:16] = wd[15:0];
    end
    return r;
  endfunction

  // Next-state logic: request capture, lane extraction and RMW merge.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          rdata_d = '0;
          if (misaligned(req_size_i, req_addr_i[1:0])) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d = 1'b0;
            if (!req_we_i)                state_d = S_LOAD;
            else if (req_size_i == SZ_WORD) state_d = S_STORE;
            else                          state_d = S_RMW_RD;
          end
        end
      end
      S_LOAD: begin
        rdata_d = extract(ram_rdata_i, size_q, addr_q[1:0], uns_q);
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        merge_d = merge(ram_rdata_i, wdata_q, size_q, addr_q[1:0]);
        state_d = S_STORE;
      end
      S_STORE: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and request latches; reset clears everything, so an interrupted
  // RMW never reaches STORE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode straight from state, so an async reset drops them at once.
  logic ram_active;
  assign ram_active   = (state_q == S_LOAD) || (state_q == S_RMW_RD) || (state_q == S_STORE);
  assign req_ready_o  = (state_q == S_IDLE);
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_err_o   = resp_valid_o & err_q;
  assign resp_rdata_o = resp_valid_o ? rdata_q : '0;
  assign ram_addr_o   = ram_active ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign ram_we_o     = (state_q == S_STORE);
  assign ram_wdata_o  = (state_q == S_STORE) ? ((size_q == SZ_WORD) ? wdata_q : merge_q) : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small behavioural dpram model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_uns = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int n_checks = 0;
  int n_errors = 0;

  // dpram model: combinational read, synchronous write
  logic [31:0] mem [0:63];
  int          wr_cnt = 0;
  logic [31:0] wr_addr = 32'h0;
  logic [31:0] wr_data = 32'h0;

  assign ram_rdata = mem[ram_addr[7:2]];

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr[7:2]] <= ram_wdata;
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= ram_addr;
      wr_data <= ram_wdata;
    end
  end

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_uns),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .resp_valid_o   (resp_valid),
    .resp_err_o     (resp_err),
    .resp_rdata_o   (resp_rdata),
    .ram_addr_o     (ram_addr),
    .ram_we_o       (ram_we),
    .ram_wdata_o    (ram_wdata),
    .ram_rdata_i    (ram_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait (bounded) for its response and check it.
  task automatic do_req(input string name, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        input int exp_lat, input logic [31:0] exp_wdata);
    int lat;
    int w0;
    int exp_w;
    bit got;
    @(negedge clk);
    check({name, ":ready"}, {31'h0, req_ready}, 32'h1);
    req_we = we; req_size = size; req_uns = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    w0 = wr_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int i = 1; i <= 8 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
        lat = i;
      end
    end
    check({name, ":lat"}, lat, exp_lat);
    check({name, ":err"}, {31'h0, resp_err}, {31'h0, exp_err});
    check({name, ":rdata"}, resp_rdata, exp_rdata);
    exp_w = (we && !exp_err) ? 1 : 0;
    check({name, ":writes"}, wr_cnt - w0, exp_w);
    if (exp_w == 1) begin
      check({name, ":waddr"}, wr_addr, {addr[31:2], 2'b00});
      check({name, ":wdata"}, wr_data, exp_wdata);
    end
    @(negedge clk);
    check({name, ":pulse"}, {31'h0, resp_valid}, 32'h0);
    check({name, ":rd0"}, resp_rdata, 32'h0);
  endtask

  logic [31:0] b2b_addr [0:2];
  logic [1:0]  b2b_size [0:2];
  logic        b2b_uns  [0:2];
  logic [31:0] b2b_exp  [0:2];

  initial begin
    int idx;
    int ridx;
    int w0;
    // Reset state
    #2;
    check("rst:ready", {31'h0, req_ready}, 32'h1);
    check("rst:rvalid", {31'h0, resp_valid}, 32'h0);
    check("rst:err", {31'h0, resp_err}, 32'h0);
    check("rst:rdata", resp_rdata, 32'h0);
    check("rst:raddr", ram_addr, 32'h0);
    check("rst:we", {31'h0, ram_we}, 32'h0);
    check("rst:wdata", ram_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store/load and sub-word traffic over word 0x10
    do_req("sw10",   1, 2'b10, 0, 32'h10, 32'h11223344, 0, 32'h0,        2, 32'h11223344);
    do_req("lw10",   0, 2'b10, 0, 32'h10, 32'h0,        0, 32'h11223344, 2, 32'h0);
    do_req("sb11",   1, 2'b00, 0, 32'h11, 32'h123456AA, 0, 32'h0,        3, 32'h11AA3344);
    do_req("lb11s",  0, 2'b00, 0, 32'h11, 32'h0,        0, 32'hFFFFFFAA, 2, 32'h0);
    do_req("lb11u",  0, 2'b00, 1, 32'h11, 32'h0,        0, 32'h000000AA, 2, 32'h0);
    do_req("lh12s",  0, 2'b01, 0, 32'h12, 32'h0,        0, 32'h00003344, 2, 32'h0);
    do_req("sh10",   1, 2'b01, 0, 32'h10, 32'hDEAD8001, 0, 32'h0,        3, 32'h80013344);
    do_req("lh10s",  0, 2'b01, 0, 32'h10, 32'h0,        0, 32'hFFFF8001, 2, 32'h0);
    do_req("lh10u",  0, 2'b01, 1, 32'h10, 32'h0,        0, 32'h00008001, 2, 32'h0);
    do_req("lb13s",  0, 2'b00, 0, 32'h13, 32'h0,        0, 32'h00000044, 2, 32'h0);
    do_req("sb13",   1, 2'b00, 0, 32'h13, 32'h000000C3, 0, 32'h0,        3, 32'h800133C3);
    do_req("lb12u",  0, 2'b00, 1, 32'h12, 32'h0,        0, 32'h00000033, 2, 32'h0);
    do_req("sb10",   1, 2'b00, 0, 32'h10, 32'h0000007E, 0, 32'h0,        3, 32'h7E0133C3);

    // Misaligned and illegal requests
    do_req("sw12e",  1, 2'b10, 0, 32'h12, 32'hCAFEF00D, 1, 32'h0,        1, 32'h0);
    do_req("lh13e",  0, 2'b01, 0, 32'h13, 32'h0,        1, 32'h0,        1, 32'h0);
    do_req("sz11e",  1, 2'b11, 0, 32'h10, 32'h12345678, 1, 32'h0,        1, 32'h0);
    do_req("lw10b",  0, 2'b10, 0, 32'h10, 32'h0,        0, 32'h7E0133C3, 2, 32'h0);

    // Back-to-back loads with valid held high
    b2b_addr[0] = 32'h10; b2b_size[0] = 2'b10; b2b_uns[0] = 0; b2b_exp[0] = 32'h7E0133C3;
    b2b_addr[1] = 32'h10; b2b_size[1] = 2'b00; b2b_uns[1] = 1; b2b_exp[1] = 32'h0000007E;
    b2b_addr[2] = 32'h12; b2b_size[2] = 2'b01; b2b_uns[2] = 0; b2b_exp[2] = 32'h000033C3;
    idx = 0;
    ridx = 0;
    req_we = 1'b0;
    for (int t = 0; t <= 9; t++) begin
      @(negedge clk);
      if (t < 9) check($sformatf("b2b:ready%0d", t), {31'h0, req_ready}, {31'h0, (t % 3 == 0)});
      if (resp_valid) begin
        if (ridx < 3) check($sformatf("b2b:rdata%0d", ridx), resp_rdata, b2b_exp[ridx]);
        ridx++;
      end
      if (req_ready) begin
        if (idx < 3) begin
          req_addr = b2b_addr[idx]; req_size = b2b_size[idx]; req_uns = b2b_uns[idx];
          req_valid = 1'b1;
          idx++;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    check("b2b:count", ridx, 3);

    // Reset in the middle of a byte RMW
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b00; req_uns = 1'b0; req_addr = 32'h10; req_wdata = 32'h55;
    req_valid = 1'b1;
    w0 = wr_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("rmwrst:rdaddr", ram_addr, 32'h10);
    check("rmwrst:rdwe", {31'h0, ram_we}, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    check("rmwrst:ready", {31'h0, req_ready}, 32'h1);
    check("rmwrst:raddr", ram_addr, 32'h0);
    check("rmwrst:rvalid", {31'h0, resp_valid}, 32'h0);
    check("rmwrst:wdata", ram_wdata, 32'h0);
    repeat (3) @(posedge clk);
    #1 check("rmwrst:we", {31'h0, ram_we}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rmwrst:nowrite", wr_cnt - w0, 0);
    do_req("lw10c",  0, 2'b10, 0, 32'h10, 32'h0,        0, 32'h7E0133C3, 2, 32'h0);
    do_req("sb10b",  1, 2'b00, 0, 32'h10, 32'h00000055, 0, 32'h0,        3, 32'h550133C3);
    do_req("lw10d",  0, 2'b10, 0, 32'h10, 32'h0,        0, 32'h550133C3, 2, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
